// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared sizes and types for the DMA engines
package dma_pkg;

  localparam int CL_SIZE_WIDTH  = 512;
  localparam int WORD_SIZE      = 32;
  localparam int WPL            = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int LINE_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PUSH,
    DONE
  } dma_wr_state_t;

  typedef logic [LINE_CNT_WIDTH-1:0] line_cnt_t;

endpackage

// File: rtl/dma_wr_packer_line_assembler.sv
// rtl/dma_wr_packer_line_assembler.sv - packs consecutive memory words into one cache line
module line_assembler #(
  parameter int CL_SIZE_WIDTH = dma_pkg::CL_SIZE_WIDTH,
  parameter int WORD_SIZE     = dma_pkg::WORD_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WORD_SIZE-1:0]     wr_data,
  output logic [CL_SIZE_WIDTH-1:0] line,
  output logic                     last_word
);

  localparam int WORDS = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0] word_cnt;

  // The word that fills the top slot completes the line.
  assign last_word = (word_cnt == LAST_SLOT);

  // Slot pointer: restarts with each new transfer, wraps after the top slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (clear) begin
      word_cnt <= '0;
    end else if (wr_en) begin
      word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
    end
  end

  // Drop each word into its slot; lowest address lands in the LSBs and other slots hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (wr_en) begin
      line[WORD_SIZE*word_cnt +: WORD_SIZE] <= wr_data;
    end
  end

endmodule

// File: rtl/dma_wr_packer.sv
// rtl/dma_wr_packer.sv - memory-to-host DMA: reads words, packs cache lines, pushes to host write FIFO
module dma_wr_packer #(
  parameter int CL_SIZE_WIDTH = dma_pkg::CL_SIZE_WIDTH,
  parameter int WORD_SIZE     = dma_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH    = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [15:0]              num_lines,
  output logic                     busy,
  output logic                     done,
  output logic                     DMAEn,
  output logic                     DMAWrEn,
  output logic [ADDR_WIDTH-1:0]    DMAAddr,
  input  logic [WORD_SIZE-1:0]     DMAOut,
  input  logic                     DMAValid,
  input  logic                     full,
  output logic                     dma_wr_en,
  output logic [CL_SIZE_WIDTH-1:0] dma_wr_data
);

  import dma_pkg::*;

  dma_wr_state_t          state;
  logic [ADDR_WIDTH-1:0]  addr;
  line_cnt_t              line_cnt;
  line_cnt_t              num_lines_q;
  logic                   word_take;
  logic                   new_xfer;
  logic                   last_word;
  logic [CL_SIZE_WIDTH-1:0] line;

  // Read data only counts while a request is outstanding.
  assign word_take = (state == WAIT) && DMAValid;
  assign new_xfer  = (state == IDLE) && start;

  // This engine never writes memory.
  assign DMAWrEn = 1'b0;
  assign DMAAddr = addr;

  // The push must follow full within the same cycle, so it is decoded from the state register.
  assign dma_wr_en   = (state == PUSH) && !full;
  assign dma_wr_data = line;

  line_assembler #(
    .CL_SIZE_WIDTH (CL_SIZE_WIDTH),
    .WORD_SIZE     (WORD_SIZE)
  ) u_line_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (new_xfer),
    .wr_en     (word_take),
    .wr_data   (DMAOut),
    .line      (line),
    .last_word (last_word)
  );

  // Transfer sequencer: one outstanding read at a time, one push per completed line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      line_cnt    <= '0;
      num_lines_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      DMAEn       <= 1'b0;
    end else begin
      DMAEn <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            addr        <= base_addr;
            num_lines_q <= num_lines;
            line_cnt    <= '0;
            if (num_lines == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= REQ;
              DMAEn <= 1'b1;
            end
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          if (DMAValid) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (last_word) begin
              state <= PUSH;
            end else begin
              state <= REQ;
              DMAEn <= 1'b1;
            end
          end
        end
        PUSH: begin
          if (!full) begin
            if (line_cnt == num_lines_q - line_cnt_t'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              line_cnt <= line_cnt + line_cnt_t'(1);
              state    <= REQ;
              DMAEn    <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_packer.sv
// tb/tb_dma_wr_packer.sv - directed self-checking bench for dma_wr_packer
module tb_dma_wr_packer;

  localparam int CLW = 512;
  localparam int WS  = 32;
  localparam int AW  = 28;
  localparam int WPL = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [15:0]    num_lines = '0;
  logic           busy, done, DMAEn, DMAWrEn;
  logic [AW-1:0]  DMAAddr;
  logic [WS-1:0]  DMAOut = '0;
  logic           DMAValid = 1'b0;
  logic           full = 1'b0;
  logic           dma_wr_en;
  logic [CLW-1:0] dma_wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [AW-1:0]  q_addr[$];
  int             q_rcyc[$];
  logic [CLW-1:0] q_line[$];
  int             q_pcyc[$];
  int             q_dcyc[$];
  int             viol = 0;
  int             valid_cnt = 0;
  bit             rand_lat = 1'b0;
  bit             stray = 1'b0;

  dma_wr_packer #(.CL_SIZE_WIDTH(CLW), .WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr),
    .DMAOut(DMAOut), .DMAValid(DMAValid), .full(full), .dma_wr_en(dma_wr_en),
    .dma_wr_data(dma_wr_data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: mem[a] = a, answers L cycles after the DMAEn cycle
  initial begin : mem_model
    int cnt;
    bit pending;
    logic [AW-1:0] pend;
    cnt = 0;
    pend = '0;
    forever begin
      @(posedge clk);
      #1;
      DMAValid = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        pending = (cnt > 0);
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            DMAValid = 1'b1;
            DMAOut = WS'(pend);
            valid_cnt++;
          end
        end
        if (DMAEn) begin
          if (pending) viol++;
          pend = DMAAddr;
          q_addr.push_back(DMAAddr);
          q_rcyc.push_back(cyc);
          cnt = rand_lat ? int'($urandom_range(1, 4)) : 1;
        end
        if (stray) begin
          DMAValid = 1'b1;
          DMAOut = 32'hDEADBEEF;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (dma_wr_en) begin
        q_line.push_back(dma_wr_data);
        q_pcyc.push_back(cyc);
      end
      if (done) q_dcyc.push_back(cyc);
    end
  end

  function automatic logic [CLW-1:0] exp_line(input logic [AW-1:0] a0);
    logic [CLW-1:0] l;
    logic [AW-1:0] a;
    l = '0;
    for (int i = 0; i < WPL; i++) begin
      a = a0 + AW'(i);
      l[WS*i +: WS] = WS'(a);
    end
    return l;
  endfunction

  task automatic kick(input logic [AW-1:0] b, input logic [15:0] n, output int c);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_lines = n;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int k;
    k = 0;
    while (q_dcyc.size() <= d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (q_dcyc.size() <= d0) begin
      n_bad++;
      $display("FAIL %s_timeout: done count %0d, required > %0d within %0d cycles", tag, q_dcyc.size(), d0, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, DMAEn, DMAWrEn, dma_wr_en} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, DMAEn, DMAWrEn, dma_wr_en});
    end
    n_cmp++;
    if (DMAAddr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h, required 0", DMAAddr);
    end
    n_cmp++;
    if (dma_wr_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h, required 0", dma_wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line();
    int c, p0, a0, d0;
    p0 = q_line.size(); a0 = q_addr.size(); d0 = q_dcyc.size();
    kick(28'h100, 16'd1, c);
    wait_done(d0, 200, "single");
    n_cmp++;
    if (q_addr.size() - a0 != 16) begin
      n_bad++;
      $display("FAIL single_req_count: got %0d, required 16", q_addr.size() - a0);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (q_addr[a0+i] !== AW'(32'h100 + i)) begin
        n_bad++;
        $display("FAIL single_addr[%0d]: got %h, required %h", i, q_addr[a0+i], AW'(32'h100 + i));
      end
    end
    n_cmp++;
    if (q_rcyc[a0] != c + 1) begin
      n_bad++;
      $display("FAIL single_first_req: got cycle %0d, required %0d", q_rcyc[a0], c + 1);
    end
    n_cmp++;
    if (q_line.size() - p0 != 1) begin
      n_bad++;
      $display("FAIL single_push_count: got %0d, required 1", q_line.size() - p0);
    end
    n_cmp++;
    if (q_line[p0] !== exp_line(28'h100)) begin
      n_bad++;
      $display("FAIL single_data: got %h, required %h", q_line[p0], exp_line(28'h100));
    end
    n_cmp++;
    if (q_pcyc[p0] != c + 33) begin
      n_bad++;
      $display("FAIL single_push_cycle: got %0d, required %0d", q_pcyc[p0], c + 33);
    end
    n_cmp++;
    if (q_dcyc[d0] != c + 34) begin
      n_bad++;
      $display("FAIL single_done_cycle: got %0d, required %0d", q_dcyc[d0], c + 34);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_after: got %b, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int c, p0, d0, k;
    p0 = q_line.size(); d0 = q_dcyc.size();
    kick(28'h100, 16'd1, c);
    k = 0;
    while (cyc < c + 33 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    full = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    wait_done(d0, 100, "bp");
    n_cmp++;
    if (q_line.size() - p0 != 1) begin
      n_bad++;
      $display("FAIL bp_push_count: got %0d, required 1", q_line.size() - p0);
    end
    n_cmp++;
    if (q_pcyc[p0] != c + 43) begin
      n_bad++;
      $display("FAIL bp_push_cycle: got %0d, required %0d", q_pcyc[p0], c + 43);
    end
    n_cmp++;
    if (q_line[p0] !== exp_line(28'h100)) begin
      n_bad++;
      $display("FAIL bp_data: got %h, required %h", q_line[p0], exp_line(28'h100));
    end
    n_cmp++;
    if (q_dcyc[d0] != c + 44) begin
      n_bad++;
      $display("FAIL bp_done_cycle: got %0d, required %0d", q_dcyc[d0], c + 44);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dma_wr_data !== exp_line(28'h100)) begin
      n_bad++;
      $display("FAIL bp_data_hold: got %h, required %h", dma_wr_data, exp_line(28'h100));
    end
  endtask

  task automatic test_multi_line();
    int c, p0, a0, d0, v0;
    p0 = q_line.size(); a0 = q_addr.size(); d0 = q_dcyc.size(); v0 = viol;
    rand_lat = 1'b1;
    kick(28'h2000, 16'd3, c);
    wait_done(d0, 400, "multi");
    rand_lat = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q_line.size() - p0 != 3) begin
      n_bad++;
      $display("FAIL multi_push_count: got %0d, required 3", q_line.size() - p0);
    end
    for (int l = 0; l < 3; l++) begin
      n_cmp++;
      if (q_line[p0+l] !== exp_line(AW'(32'h2000 + 16 * l))) begin
        n_bad++;
        $display("FAIL multi_line[%0d]: got %h, required %h", l, q_line[p0+l], exp_line(AW'(32'h2000 + 16 * l)));
      end
    end
    n_cmp++;
    if (q_addr.size() - a0 != 48) begin
      n_bad++;
      $display("FAIL multi_req_count: got %0d, required 48", q_addr.size() - a0);
    end
    for (int i = 0; i < 48; i++) begin
      n_cmp++;
      if (q_addr[a0+i] !== AW'(32'h2000 + i)) begin
        n_bad++;
        $display("FAIL multi_addr[%0d]: got %h, required %h", i, q_addr[a0+i], AW'(32'h2000 + i));
      end
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++;
      $display("FAIL multi_outstanding: got %0d overlapping requests, required 0", viol - v0);
    end
    n_cmp++;
    if (q_dcyc.size() - d0 != 1) begin
      n_bad++;
      $display("FAIL multi_done_count: got %0d, required 1", q_dcyc.size() - d0);
    end
  endtask

  task automatic test_zero_and_ignored();
    int c, c2, p0, a0, d0;
    logic [CLW-1:0] hold;
    p0 = q_line.size(); a0 = q_addr.size(); d0 = q_dcyc.size();
    kick(28'h0, 16'd0, c);
    wait_done(d0, 10, "zero");
    n_cmp++;
    if (q_dcyc[d0] != c + 1) begin
      n_bad++;
      $display("FAIL zero_done_cycle: got %0d, required %0d", q_dcyc[d0], c + 1);
    end
    n_cmp++;
    if (q_addr.size() != a0 || q_line.size() != p0) begin
      n_bad++;
      $display("FAIL zero_traffic: got %0d reqs %0d pushes, required 0 0", q_addr.size() - a0, q_line.size() - p0);
    end
    hold = dma_wr_data;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dma_wr_data !== hold) begin
      n_bad++;
      $display("FAIL stray_valid: got busy %b data %h, required busy 0 data %h", busy, dma_wr_data, hold);
    end
    p0 = q_line.size(); a0 = q_addr.size(); d0 = q_dcyc.size();
    kick(28'h300, 16'd2, c);
    repeat (8) @(negedge clk);
    kick(28'h999, 16'd5, c2);
    wait_done(d0, 200, "ignored");
    repeat (5) @(negedge clk);
    n_cmp++;
    if (q_line.size() - p0 != 2) begin
      n_bad++;
      $display("FAIL ignored_push_count: got %0d, required 2", q_line.size() - p0);
    end
    n_cmp++;
    if (q_line[p0] !== exp_line(28'h300) || q_line[p0+1] !== exp_line(28'h310)) begin
      n_bad++;
      $display("FAIL ignored_data: got %h, required %h", q_line[p0+1], exp_line(28'h310));
    end
    n_cmp++;
    if (q_dcyc[d0] != c + 67) begin
      n_bad++;
      $display("FAIL ignored_done_cycle: got %0d, required %0d", q_dcyc[d0], c + 67);
    end
    n_cmp++;
    if (q_addr.size() - a0 != 32) begin
      n_bad++;
      $display("FAIL ignored_req_count: got %0d, required 32", q_addr.size() - a0);
    end
  endtask

  task automatic test_addr_wrap();
    int c, p0, a0, d0;
    p0 = q_line.size(); a0 = q_addr.size(); d0 = q_dcyc.size();
    kick(28'hFFFFFF8, 16'd1, c);
    wait_done(d0, 200, "wrap");
    n_cmp++;
    if (q_addr[a0] !== 28'hFFFFFF8 || q_addr[a0+7] !== 28'hFFFFFFF) begin
      n_bad++;
      $display("FAIL wrap_addr_hi: got %h..%h, required ffffff8..fffffff", q_addr[a0], q_addr[a0+7]);
    end
    n_cmp++;
    if (q_addr[a0+8] !== 28'h0000000 || q_addr[a0+15] !== 28'h0000007) begin
      n_bad++;
      $display("FAIL wrap_addr_lo: got %h..%h, required 0000000..0000007", q_addr[a0+8], q_addr[a0+15]);
    end
    n_cmp++;
    if (q_line[p0] !== exp_line(28'hFFFFFF8)) begin
      n_bad++;
      $display("FAIL wrap_data: got %h, required %h", q_line[p0], exp_line(28'hFFFFFF8));
    end
  endtask

  task automatic test_reset_mid();
    int c, k, p0, d0, v0;
    p0 = q_line.size(); d0 = q_dcyc.size(); v0 = valid_cnt;
    kick(28'h400, 16'd1, c);
    k = 0;
    while (valid_cnt < v0 + 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, DMAEn, dma_wr_en} !== 4'b0 || DMAAddr !== '0 || dma_wr_data !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got ctrl %b addr %h, required 0000 0", {busy, done, DMAEn, dma_wr_en}, DMAAddr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (q_line.size() != p0 || q_dcyc.size() != d0) begin
      n_bad++;
      $display("FAIL midrst_no_push_done: got %0d pushes %0d dones, required 0 0", q_line.size() - p0, q_dcyc.size() - d0);
    end
    kick(28'h500, 16'd1, c);
    wait_done(d0, 200, "midrst");
    n_cmp++;
    if (q_line[p0] !== exp_line(28'h500)) begin
      n_bad++;
      $display("FAIL midrst_fresh_data: got %h, required %h", q_line[p0], exp_line(28'h500));
    end
    n_cmp++;
    if (q_dcyc[d0] != c + 34) begin
      n_bad++;
      $display("FAIL midrst_done_cycle: got %0d, required %0d", q_dcyc[d0], c + 34);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_multi_line();
    test_zero_and_ignored();
    test_addr_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
